// File: rtl/wb_serial_pkg.sv
// Shared definitions for both ends of the serial Wishbone link:
// command nibbles, response status code and the initiator FSM states.
package wb_serial_pkg;

  localparam logic [3:0] CMD_RD    = 4'h1;
  localparam logic [3:0] CMD_WR    = 4'h2;
  localparam logic [7:0] STATUS_OK = 8'h5A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_STAT,
    ST_RDATA,
    ST_FIN
  } ser_state_e;

endpackage

// File: rtl/wb_serial_initiator.sv
// Wishbone slave that serializes each single cycle into a byte command frame
// and completes it from the remote responder's byte reply (or a timeout).
module wb_serial_initiator
  import wb_serial_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd12_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready
);

  ser_state_e  state, state_d;
  logic [1:0]  cnt;
  logic [63:0] tx_sr;
  logic [31:0] rx_sr;
  logic [23:0] tmo_cnt;
  logic        we_q;
  logic        abort_q;
  logic        done_ok, done_err;

  logic tx_hs, rx_hs, req, rx_ok, tmo_hit, abort_now, in_rsp;
  assign tx_hs     = m_axis_tvalid & m_axis_tready;
  assign rx_hs     = s_axis_tvalid & s_axis_tready;
  assign req       = wb_cyc_i & wb_stb_i;
  assign rx_ok     = (s_axis_tdata == STATUS_OK);
  assign in_rsp    = (state == ST_STAT) || (state == ST_RDATA);
  assign tmo_hit   = (TIMEOUT_CYCLES != 24'd0) && (tmo_cnt == TIMEOUT_CYCLES - 24'd1);
  // A dropped cyc still runs the frame to completion; only the pulse is hidden.
  assign abort_now = abort_q | ~wb_cyc_i;

  always_comb begin
    state_d  = state;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state)
      ST_IDLE:  if (req) state_d = ST_CMD;
      ST_CMD:   if (tx_hs) state_d = ST_ADDR;
      ST_ADDR:  if (tx_hs && cnt == 2'd3) state_d = we_q ? ST_DATA : ST_STAT;
      ST_DATA:  if (tx_hs && cnt == 2'd3) state_d = ST_STAT;
      ST_STAT: begin
        if (rx_hs) begin
          if (rx_ok && !we_q) begin
            state_d = ST_RDATA;
          end else begin
            state_d  = ST_FIN;
            done_ok  = rx_ok;
            done_err = ~rx_ok;
          end
        end else if (tmo_hit) begin
          state_d  = ST_FIN;
          done_err = 1'b1;
        end
      end
      ST_RDATA: begin
        if (rx_hs) begin
          if (cnt == 2'd3) begin
            state_d = ST_FIN;
            done_ok = 1'b1;
          end
        end else if (tmo_hit) begin
          state_d  = ST_FIN;
          done_err = 1'b1;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= ST_IDLE;
      cnt           <= 2'd0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      tmo_cnt       <= '0;
      we_q          <= 1'b0;
      abort_q       <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      s_axis_tready <= 1'b0;
      wb_ack_o      <= 1'b0;
      wb_err_o      <= 1'b0;
      wb_dat_o      <= '0;
    end else begin
      state         <= state_d;
      s_axis_tready <= (state_d == ST_IDLE) || (state_d == ST_STAT) || (state_d == ST_RDATA);

      if (state_d != state)
        cnt <= 2'd0;
      else if ((tx_hs && (state == ST_ADDR || state == ST_DATA)) || (rx_hs && state == ST_RDATA))
        cnt <= cnt + 2'd1;

      if (state == ST_IDLE && req) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= {wb_we_i ? CMD_WR : CMD_RD, wb_sel_i};
        tx_sr         <= {wb_adr_i, wb_dat_i};
        we_q          <= wb_we_i;
      end else if (tx_hs) begin
        if (state_d == ST_STAT) begin
          m_axis_tvalid <= 1'b0;
        end else begin
          m_axis_tdata <= tx_sr[63:56];
          tx_sr        <= {tx_sr[55:0], 8'h00};
        end
      end

      if (rx_hs && state == ST_RDATA)
        rx_sr <= {rx_sr[23:0], s_axis_tdata};

      tmo_cnt <= (rx_hs || !in_rsp) ? 24'd0 : tmo_cnt + 24'd1;

      if (state == ST_IDLE)
        abort_q <= 1'b0;
      else if (!wb_cyc_i)
        abort_q <= 1'b1;

      wb_ack_o <= done_ok & ~abort_now;
      wb_err_o <= done_err & ~abort_now;
      wb_dat_o <= (done_ok && !we_q && !abort_now) ? {rx_sr[23:0], s_axis_tdata} : 32'd0;
    end
  end

endmodule

// File: tb/tb_wb_serial_initiator.sv
// Scoreboard bench for wb_serial_initiator: expected TX bytes and completions
// are queued as stimulus is issued and checked by a negedge monitor.
module tb_wb_serial_initiator;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic        wb_we_i = 1'b0, wb_cyc_i = 1'b0, wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;

  wb_serial_initiator #(.TIMEOUT_CYCLES(24'd100)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic        chk_dat;
    logic [31:0] dat;
  } done_t;

  logic [7:0] exp_tx[$];
  done_t      exp_done[$];
  int n_checks = 0, n_fail = 0, n_pulses = 0;
  int cyc = 0, last_tx_cyc = 0, last_done_cyc = 0;
  bit rand_rdy = 1'b0;

  initial forever begin
    @(posedge i_clk);
    cyc++;
  end

  initial forever begin
    @(posedge i_clk);
    #1;
    m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: TX scoreboard, stall stability and completion scoreboard.
  initial begin
    logic       stall_q;
    logic [7:0] stall_dat, e;
    done_t      d;
    stall_q = 1'b0;
    stall_dat = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        stall_q = 1'b0;
      end else begin
        if (stall_q) begin
          n_checks++;
          if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== stall_dat) begin
            n_fail++;
            $display("FAIL tx_stable: tvalid=%0b tdata=%02h required tvalid=1 tdata=%02h",
                     m_axis_tvalid, m_axis_tdata, stall_dat);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          n_checks++;
          last_tx_cyc = cyc;
          if (exp_tx.size() == 0) begin
            n_fail++;
            $display("FAIL tx_byte: got %02h with nothing expected", m_axis_tdata);
          end else begin
            e = exp_tx.pop_front();
            if (m_axis_tdata !== e) begin
              n_fail++;
              $display("FAIL tx_byte: got %02h required %02h", m_axis_tdata, e);
            end
          end
        end
        if (wb_ack_o || wb_err_o) begin
          n_checks++;
          n_pulses++;
          last_done_cyc = cyc;
          if (exp_done.size() == 0) begin
            n_fail++;
            $display("FAIL done_pulse: ack=%0b err=%0b with nothing expected", wb_ack_o, wb_err_o);
          end else begin
            d = exp_done.pop_front();
            if (wb_ack_o !== d.ack || wb_err_o !== d.err || (d.chk_dat && wb_dat_o !== d.dat)) begin
              n_fail++;
              $display("FAIL done_pulse: ack=%0b err=%0b dat=%08h required ack=%0b err=%0b dat=%08h",
                       wb_ack_o, wb_err_o, wb_dat_o, d.ack, d.err, d.dat);
            end
          end
        end
        stall_q   = m_axis_tvalid && !m_axis_tready;
        stall_dat = m_axis_tdata;
      end
    end
  end

  task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel);
    @(posedge i_clk);
    #1;
    wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    exp_tx.push_back({we ? 4'h2 : 4'h1, sel});
    for (int i = 3; i >= 0; i--) exp_tx.push_back(adr[i*8 +: 8]);
    if (we) for (int i = 3; i >= 0; i--) exp_tx.push_back(dat[i*8 +: 8]);
  endtask

  task automatic wait_tx_empty(input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      @(negedge i_clk);
      n++;
    end
    n_checks++;
    if (exp_tx.size() != 0) begin
      n_fail++;
      $display("FAIL tx_drain: %0d bytes still outstanding, required 0", exp_tx.size());
    end
  endtask

  task automatic send_rsp(input logic [7:0] b);
    int n = 0;
    @(posedge i_clk);
    #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    do begin
      @(negedge i_clk);
      n++;
    end while (!s_axis_tready && n < 200);
    if (!s_axis_tready) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_accept: byte %02h not accepted, tready=0 required 1", b);
    end
    @(posedge i_clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!(wb_ack_o || wb_err_o) && n < budget);
    n_checks++;
    if (!(wb_ack_o || wb_err_o)) begin
      n_fail++;
      $display("FAIL done_wait: no ack/err within %0d cycles", budget);
    end
    @(posedge i_clk);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (exp_done.size() != 0) begin
      n_fail++;
      $display("FAIL done_count: %0d completions outstanding, required 0", exp_done.size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({m_axis_tvalid, s_axis_tready, wb_ack_o, wb_err_o, m_axis_tdata, wb_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: tv=%0b sr=%0b ack=%0b err=%0b td=%02h dat=%08h required all 0",
               m_axis_tvalid, s_axis_tready, wb_ack_o, wb_err_o, m_axis_tdata, wb_dat_o);
    end
    #1 i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if (s_axis_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_tready: got %0b required 1", s_axis_tready);
    end
  endtask

  task automatic test_write;
    start_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
    wait_tx_empty(50);
    exp_done.push_back('{ack: 1'b1, err: 1'b0, chk_dat: 1'b0, dat: 32'd0});
    send_rsp(8'h5A);
    wait_done(20);
  endtask

  task automatic test_read;
    start_req(1'b0, 32'h0000_0004, 32'h0, 4'h3);
    wait_tx_empty(50);
    exp_done.push_back('{ack: 1'b1, err: 1'b0, chk_dat: 1'b1, dat: 32'h1234_5678});
    send_rsp(8'h5A); send_rsp(8'h12); send_rsp(8'h34); send_rsp(8'h56); send_rsp(8'h78);
    wait_done(20);
  endtask

  task automatic test_read_err;
    start_req(1'b0, 32'h0000_0020, 32'h0, 4'hF);
    wait_tx_empty(50);
    exp_done.push_back('{ack: 1'b0, err: 1'b1, chk_dat: 1'b1, dat: 32'd0});
    send_rsp(8'hE1);
    wait_done(20);
  endtask

  task automatic test_timeout;
    int p0;
    start_req(1'b0, 32'h0000_0030, 32'h0, 4'hF);
    wait_tx_empty(50);
    exp_done.push_back('{ack: 1'b0, err: 1'b1, chk_dat: 1'b1, dat: 32'd0});
    wait_done(300);
    n_checks++;
    if (last_done_cyc - last_tx_cyc != 101) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles required 101", last_done_cyc - last_tx_cyc);
    end
    p0 = n_pulses;
    send_rsp(8'h5A);
    repeat (6) @(negedge i_clk);
    n_checks++;
    if (n_pulses != p0) begin
      n_fail++;
      $display("FAIL late_byte: got %0d pulses required 0", n_pulses - p0);
    end
  endtask

  task automatic test_stall_write;
    rand_rdy = 1'b1;
    start_req(1'b1, 32'hA5A5_0004, 32'h0123_4567, 4'h5);
    wait_tx_empty(300);
    rand_rdy = 1'b0;
    exp_done.push_back('{ack: 1'b1, err: 1'b0, chk_dat: 1'b0, dat: 32'd0});
    send_rsp(8'h5A);
    wait_done(20);
  endtask

  task automatic test_reset_midframe;
    int n = 0;
    start_req(1'b0, 32'h1122_3344, 32'h0, 4'hF);
    do begin
      @(negedge i_clk);
      n++;
    end while (!(m_axis_tvalid && m_axis_tdata == 8'h33) && n < 50);
    #1 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({m_axis_tvalid, s_axis_tready, wb_ack_o, wb_err_o, m_axis_tdata, wb_dat_o} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: tv=%0b sr=%0b ack=%0b err=%0b td=%02h dat=%08h required all 0",
               m_axis_tvalid, s_axis_tready, wb_ack_o, wb_err_o, m_axis_tdata, wb_dat_o);
    end
    exp_tx.delete();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    start_req(1'b0, 32'h0000_0008, 32'h0, 4'hF);
    wait_tx_empty(50);
    exp_done.push_back('{ack: 1'b1, err: 1'b0, chk_dat: 1'b1, dat: 32'hCAFE_F00D});
    send_rsp(8'h5A); send_rsp(8'hCA); send_rsp(8'hFE); send_rsp(8'hF0); send_rsp(8'h0D);
    wait_done(20);
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_read_err;
    test_timeout;
    test_stall_write;
    test_reset_midframe;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
